// File: rtl/render_pkg.sv
// Shared render-pipeline types: pixel word, default raster size, frame-writer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   H_RES_DEF / V_RES_DEF : default raster geometry
//   pixel_t               : 24-bit 8R:8G:8B pixel, R in [23:16]
//   fb_wr_state_t         : frame-buffer writer FSM encoding
//   cnt_width()           : counter width that stays >= 1 for degenerate sizes
package render_pkg;

  localparam int H_RES_DEF  = 320;
  localparam int V_RES_DEF  = 180;
  localparam int PIXEL_BITS = 24;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_wr_state_t;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y/linear-index counter with end-of-frame flag; shared with the display reader.
// Latency: counters update on the clock after adv/clr; last is combinational from current count.
// Backpressure: none; advances only when adv is asserted.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : return to pixel 0 (wins over adv)
//   adv      : step to the next pixel; wraps to 0 after the last pixel of the frame
//   x, y     : current column / line
//   idx      : current linear index, always y*H_RES+x
//   last     : current position is the final pixel of the frame
module raster_counter
  import render_pkg::*;
#(
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int IDX_BITS = $clog2(H_RES * V_RES),
  localparam int XW      = cnt_width(H_RES),
  localparam int YW      = cnt_width(V_RES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                adv,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [IDX_BITS-1:0] idx,
  output logic                last
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                x_last;

  assign x_last = (x_q == X_LAST);
  assign last   = x_last && (y_q == Y_LAST);

  // idx is carried as its own incrementing counter so no y*H_RES multiply is needed.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    idx_d = idx_q;
    if (clr || (adv && last)) begin
      x_d   = '0;
      y_d   = '0;
      idx_d = '0;
    end else if (adv) begin
      idx_d = idx_q + 1'b1;
      if (x_last) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      idx_q <= idx_d;
    end
  end

  assign x   = x_q;
  assign y   = y_q;
  assign idx = idx_q;

endmodule

// File: rtl/pixel_fb_writer.sv
// Writes the shaded pixel stream in raster order into one bank of a double-buffered frame buffer.
// Latency: BRAM write strobe exactly 1 cycle after each accepted pixel; frame_done rides the last write.
// Backpressure: tready is a registered state decode; low outside WRITE, so the stream stalls until frame_start.
//
// Ports:
//   aclk, areset        : clock, synchronous active-high reset
//   pixel_axis_t*       : AXI-stream pixel input (tdata/tvalid/tready)
//   frame_start         : pulse, arms the writer for one frame (only honoured when idle)
//   display_vsync       : pulse from the display reader, swaps banks once a frame is complete
//   fb_wr_addr/data/en  : BRAM write port, address is {bank, linear pixel index}
//   display_bank        : bank the display reader scans (never the one being written)
//   frame_done          : pulse with the final pixel's write
//   busy                : writer is not idle
module pixel_fb_writer
  import render_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int COLOR_BITS = PIXEL_BITS,
  parameter int ADDR_BITS  = $clog2(H_RES * V_RES)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [COLOR_BITS-1:0] pixel_axis_tdata,
  input  logic                  pixel_axis_tvalid,
  output logic                  pixel_axis_tready,
  input  logic                  frame_start,
  input  logic                  display_vsync,
  output logic [ADDR_BITS:0]    fb_wr_addr,
  output logic [COLOR_BITS-1:0] fb_wr_data,
  output logic                  fb_wr_en,
  output logic                  display_bank,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int XW = cnt_width(H_RES);
  localparam int YW = cnt_width(V_RES);

  fb_wr_state_t          state_q, state_d;
  logic                  tready_q, tready_d;
  logic                  write_bank_q, write_bank_d;
  logic                  display_bank_q, display_bank_d;
  logic                  fb_wr_en_q, fb_wr_en_d;
  logic [ADDR_BITS:0]    fb_wr_addr_q, fb_wr_addr_d;
  logic [COLOR_BITS-1:0] fb_wr_data_q, fb_wr_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;

  logic                  hs;
  logic                  cnt_clr;
  logic [XW-1:0]         cnt_x;
  logic [YW-1:0]         cnt_y;
  logic [ADDR_BITS-1:0]  cnt_idx;
  logic                  cnt_last;

  // tready_q is only ever high in WRITE, so this is the accepted-pixel strobe.
  assign hs = pixel_axis_tvalid && tready_q;

  raster_counter #(
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .IDX_BITS (ADDR_BITS)
  ) u_raster_counter (
    .clk  (aclk),
    .rst  (areset),
    .clr  (cnt_clr),
    .adv  (hs),
    .x    (cnt_x),
    .y    (cnt_y),
    .idx  (cnt_idx),
    .last (cnt_last)
  );

  always_comb begin
    state_d        = state_q;
    write_bank_d   = write_bank_q;
    display_bank_d = display_bank_q;
    fb_wr_en_d     = 1'b0;
    fb_wr_addr_d   = fb_wr_addr_q;
    fb_wr_data_d   = fb_wr_data_q;
    frame_done_d   = 1'b0;
    cnt_clr        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = WRITE;
          cnt_clr = 1'b1;
        end
      end
      WRITE: begin
        // display_vsync and frame_start are deliberately not looked at here.
        if (hs) begin
          fb_wr_en_d   = 1'b1;
          fb_wr_data_d = pixel_axis_tdata;
          fb_wr_addr_d = {write_bank_q, cnt_idx};
          if (cnt_last) begin
            frame_done_d = 1'b1;
            state_d      = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (display_vsync) begin
          display_bank_d = write_bank_q;
          write_bank_d   = ~write_bank_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Decoded from the next state so tready and busy line up with state_q.
    tready_d = (state_d == WRITE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= IDLE;
      tready_q       <= 1'b0;
      write_bank_q   <= 1'b0;
      display_bank_q <= 1'b1;
      fb_wr_en_q     <= 1'b0;
      fb_wr_addr_q   <= '0;
      fb_wr_data_q   <= '0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tready_q       <= tready_d;
      write_bank_q   <= write_bank_d;
      display_bank_q <= display_bank_d;
      fb_wr_en_q     <= fb_wr_en_d;
      fb_wr_addr_q   <= fb_wr_addr_d;
      fb_wr_data_q   <= fb_wr_data_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
    end
  end

  // The linear index must stay in lock-step with the x/y position.
  idx_matches_xy: assert property (@(posedge aclk) disable iff (areset)
    int'(cnt_idx) == int'(cnt_y) * H_RES + int'(cnt_x));

  assign pixel_axis_tready = tready_q;
  assign fb_wr_addr        = fb_wr_addr_q;
  assign fb_wr_data        = fb_wr_data_q;
  assign fb_wr_en          = fb_wr_en_q;
  assign display_bank      = display_bank_q;
  assign frame_done        = frame_done_q;
  assign busy              = busy_q;

endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Sink end of the shader pixel stream: consumes the 24-bit RGB pixel AXI-stream that the lambert shading stage emits.
- Places each pixel in raster order into one bank of a double-buffered frame buffer (BRAM write port).
- Signals frame completion and swaps banks on a display-side vsync acknowledge, so the display reader never scans a half-written frame.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 180, lines per frame.
- COLOR_BITS, 24, pixel width (8R:8G:8B, R in [23:16]).
- ADDR_BITS, $clog2(H_RES*V_RES), per-bank address width; the bank bit is an extra MSB.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- pixel_axis_tdata  in  COLOR_BITS  shaded pixel.
- pixel_axis_tvalid  in  1  pixel valid.
- pixel_axis_tready  out  1  block accepts pixel.
- frame_start  in  1  one-cycle pulse: begin accepting a new frame.
- display_vsync  in  1  one-cycle pulse from display reader at vertical blank.
- fb_wr_addr  out  ADDR_BITS+1  {bank, linear pixel index}.
- fb_wr_data  out  COLOR_BITS  pixel to write.
- fb_wr_en  out  1  write strobe.
- display_bank  out  1  bank the display reader must scan.
- frame_done  out  1  one-cycle pulse: last pixel of frame written.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, aclk. Reset is synchronous and active-high (areset).
- Reset values:
  - state=IDLE; x=0, y=0, idx=0.
  - write_bank=0, display_bank=1.
  - tready=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0.
  - frame_done=0, busy=0.
- FSM states: IDLE, WRITE, WAIT_SWAP.
  - IDLE: tready=0. On frame_start go to WRITE; clear x, y, idx.
  - WRITE: tready=1. Handshake occurs when tvalid&&tready.
    - On handshake, the next cycle has fb_wr_en=1, fb_wr_data=tdata, fb_wr_addr={write_bank, idx}. Latency is exactly 1 cycle.
    - Counter update: x++. At x==H_RES-1, x wraps to 0 and y++. idx++.
    - Handshake on x==H_RES-1 && y==V_RES-1: counters clear, frame_done pulses on the same cycle as that pixel's fb_wr_en, and the FSM goes to WAIT_SWAP.
  - WAIT_SWAP: tready=0. On display_vsync: display_bank<=write_bank, write_bank<=~write_bank, go to IDLE.
- tready is a registered decode of state; it never depends combinationally on tvalid.
- fb_wr_en is low on every cycle with no handshake, including tvalid-low gaps in WRITE.
- Simultaneous events:
  - frame_start outside IDLE is ignored, not queued.
  - display_vsync outside WAIT_SWAP is ignored.
  - frame_start in the same cycle as reset: reset wins.
  - display_vsync in the cycle WRITE completes the last pixel: ignored; the block waits for the next vsync.
- Reset mid-frame discards the partial frame. No fb_wr_en on the cycle after reset asserts. Bank assignment returns to write 0 / display 1.
- Arithmetic: idx equals y*H_RES+x by construction. It is an incrementing counter; no multiplier.

Decomposition:
- Shared package (render_pkg):
  - typedef pixel_t (logic [23:0]).
  - H_RES/V_RES default constants.
  - FSM enum fb_wr_state_t {IDLE, WRITE, WAIT_SWAP}.
- One natural sub-module: raster_counter (x/y/idx counters with wrap and last flag). It is reusable by the display reader.

Test Plan (H_RES=4, V_RES=2):
- Reset, pulse frame_start, then stream 8 pixels 0x000001..0x000008 with tvalid held high.
  - Expected: fb_wr_en writes addr 0..7 (bank 0) with data 1..8, each one cycle after its handshake.
  - frame_done pulses with the addr-7 write; busy stays high; tready falls.
- Same stream with tvalid toggling 1,0,1,0.
  - Expected: exactly 8 writes, no fb_wr_en during gaps, addresses contiguous 0..7.
- After frame 1, pulse display_vsync.
  - Expected: display_bank=0; the next frame's writes go to addr 8..15 (bank bit 1).
  - A third frame returns to bank 0.
- Pulse frame_start during WRITE (pixel 3) and display_vsync during WRITE.
  - Expected: no counter reset, no bank change, frame completes normally at 8 pixels.
- Assert areset after pixel 5 of a frame.
  - Expected: next cycle fb_wr_en=0, tready=0, busy=0, display_bank=1.
  - A new frame_start rewrites from addr 0.
- tvalid high while in IDLE or WAIT_SWAP.
  - Expected: tready=0 and no writes, no matter how long tvalid is held.
